// File: rtl/data_structs_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// data_structs : shared pixel-path types (spectrum, rgb, pixel_tag)
// Rev 1.0
// ---------------------------------------------------------------------------
package data_structs;

  localparam int TAG_COORD_W = 16;

  // Three unsigned Q1.16 radiance channels.
  typedef struct packed {
    logic [16:0] r;
    logic [16:0] g;
    logic [16:0] b;
  } spectrum;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb;

  typedef struct packed {
    logic [TAG_COORD_W-1:0] x;
    logic [TAG_COORD_W-1:0] y;
    logic                   eol;
    logic                   eof;
  } pixel_tag;

  localparam logic [7:0] RGB_MAX = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/q116_to_u8.sv
`default_nettype none
// ---------------------------------------------------------------------------
// q116_to_u8 : one Q1.16 channel to 8-bit colour, saturating and rounding
// Rev 1.0
// ---------------------------------------------------------------------------
module q116_to_u8
  import data_structs::*;
(
  input  logic [16:0] c_i,
  output logic [7:0]  u8_o
);

  // 0xFFFF*255 + 0x8000 still fits in 24 bits.
  logic [23:0] scaled;

  assign scaled = 24'(c_i[15:0]) * 24'd255 + 24'd32768;
  assign u8_o   = c_i[16] ? RGB_MAX : 8'(scaled >> 16);

endmodule
`default_nettype wire

// File: rtl/pixel_output_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pixel_output_stage : 2-stage spectrum-to-RGB pipeline with raster tagging
// Rev 1.0
// ---------------------------------------------------------------------------
module pixel_output_stage
  import data_structs::*;
#(
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  spectrum                    in_spec,
  output logic                       out_valid,
  input  logic                       out_ready,
  output rgb                         out_rgb,
  output logic [$clog2(H_RES)-1:0]   out_x,
  output logic [$clog2(V_RES)-1:0]   out_y,
  output logic                       out_eol,
  output logic                       out_eof,
  output logic [15:0]                frame_count
);

  localparam int XW = $clog2(H_RES);
  localparam int YW = $clog2(V_RES);

  logic           adv;
  logic           accept;
  logic [XW-1:0]  x_q, x_d;
  logic [YW-1:0]  y_q, y_d;
  logic [15:0]    fc_q, fc_d;
  pixel_tag       tag_in;

  logic           s1_valid_q;
  spectrum        s1_spec_q;
  pixel_tag       s1_tag_q;

  logic           out_valid_q;
  rgb             out_rgb_q;
  pixel_tag       out_tag_q;
  rgb             conv;
  logic           unused_tag_hi;

  // Stall depends only on the output handshake, never on in_valid.
  assign adv      = !out_valid_q || out_ready;
  assign accept   = in_valid && adv;
  assign in_ready = adv;

  always_comb begin
    tag_in     = '0;
    tag_in.x   = TAG_COORD_W'(x_q);
    tag_in.y   = TAG_COORD_W'(y_q);
    tag_in.eol = (x_q == XW'(H_RES - 1));
    tag_in.eof = tag_in.eol && (y_q == YW'(V_RES - 1));
    x_d  = x_q;
    y_d  = y_q;
    fc_d = fc_q;
    if (accept) begin
      if (tag_in.eol) begin
        x_d = '0;
        if (tag_in.eof) begin
          y_d  = '0;
          fc_d = fc_q + 16'd1;
        end else begin
          y_d = y_q + YW'(1);
        end
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  q116_to_u8 u_conv_r (.c_i(s1_spec_q.r), .u8_o(conv.r));
  q116_to_u8 u_conv_g (.c_i(s1_spec_q.g), .u8_o(conv.g));
  q116_to_u8 u_conv_b (.c_i(s1_spec_q.b), .u8_o(conv.b));

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q         <= '0;
      y_q         <= '0;
      fc_q        <= '0;
      s1_valid_q  <= 1'b0;
      s1_spec_q   <= '0;
      s1_tag_q    <= '0;
      out_valid_q <= 1'b0;
      out_rgb_q   <= '0;
      out_tag_q   <= '0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      fc_q <= fc_d;
      if (adv) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_spec_q <= in_spec;
          s1_tag_q  <= tag_in;
        end
        out_valid_q <= s1_valid_q;
        // Bubbles leave the previous pixel's data on the output registers.
        if (s1_valid_q) begin
          out_rgb_q <= conv;
          out_tag_q <= s1_tag_q;
        end
      end
    end
  end

  assign out_valid     = out_valid_q;
  assign out_rgb       = out_rgb_q;
  assign out_x         = out_tag_q.x[XW-1:0];
  assign out_y         = out_tag_q.y[YW-1:0];
  assign out_eol       = out_tag_q.eol;
  assign out_eof       = out_tag_q.eof;
  assign frame_count   = fc_q;
  assign unused_tag_hi = ^{out_tag_q.x, out_tag_q.y};

endmodule
`default_nettype wire
